// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: front-panel buttons, run length and datapath control bundle.
//   master : drives buttons and run_len, observes controller outputs (bench / panel side)
//   slave  : seq_ctrl side; receives buttons and run_len, drives the datapath controls
//   btn_start/btn_stop/btn_step/btn_dir : raw active-high buttons
//   run_len    : ticks per bounded run, 0 = unlimited
//   tick_en    : one-cycle datapath register enable
//   up         : count direction
//   ini        : datapath held at its initial state
//   busy       : high while running
//   mode       : 00 IDLE, 01 RUN, 10 PAUSE, 11 STEP
//   steps_left : remaining ticks in a bounded run
interface seq_ctrl_if;
   logic       btn_start;
   logic       btn_stop;
   logic       btn_step;
   logic       btn_dir;
   logic [3:0] run_len;
   logic       tick_en;
   logic       up;
   logic       ini;
   logic       busy;
   logic [1:0] mode;
   logic [3:0] steps_left;

   modport master (
      output btn_start, btn_stop, btn_step, btn_dir, run_len,
      input  tick_en, up, ini, busy, mode, steps_left
   );

   modport slave (
      input  btn_start, btn_stop, btn_step, btn_dir, run_len,
      output tick_en, up, ini, busy, mode, steps_left
   );
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: run controller for the 3-bit state register / 7-segment datapath.
// Debounces the four front-panel buttons and runs the IDLE/RUN/PAUSE/STEP mode
// FSM that sources the datapath enable, direction and initial-load controls.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seq_ctrl_if.slave (buttons, run_len in; tick_en, up, ini, busy,
//           mode, steps_left out; all outputs come straight from flops)
module seq_ctrl #(
   parameter int unsigned DIV   = 16666666,
   parameter int unsigned DIV_W = 25,
   parameter int unsigned DEB   = 500000,
   parameter int unsigned DEB_W = 20
) (
   input  logic       clock,
   input  logic       reset,
   seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      STEP  = 2'b11
   } state_t;

   localparam int unsigned NBTN    = 4;
   localparam int unsigned B_START = 0;
   localparam int unsigned B_STOP  = 1;
   localparam int unsigned B_STEP  = 2;
   localparam int unsigned B_DIR   = 3;

   logic [NBTN-1:0]  raw;
   logic [NBTN-1:0]  level;
   logic [NBTN-1:0]  ev;
   logic [DEB_W-1:0] deb_cnt [NBTN];

   state_t           state, state_n;
   logic [DIV_W-1:0] div, div_n;
   logic [3:0]       steps, steps_n;
   logic [3:0]       rl_lat, rl_n;
   logic             tick_n;
   logic             tick_q, up_q, ini_q, busy_q;
   logic             div_last;
   logic             run_done;

   assign raw = {bus.btn_dir, bus.btn_step, bus.btn_stop, bus.btn_start};

   // Debounce: level follows raw after DEB consecutive differing cycles; a rising
   // level change emits a registered one-cycle event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level <= '0;
         ev    <= '0;
         for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            ev[i] <= 1'b0;
            if (raw[i] == level[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEB - 1)) begin
               level[i]   <= raw[i];
               deb_cnt[i] <= '0;
               ev[i]      <= raw[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign div_last = (div == DIV_W'(DIV - 1));
   // Last tick of a bounded run is on tick_en now; leave RUN one cycle after it.
   assign run_done = tick_q && (rl_lat != 4'd0) && (steps == 4'd0);

   // Next-state, divider, step counter and tick request.
   always_comb begin
      state_n = state;
      div_n   = div;
      steps_n = steps;
      rl_n    = rl_lat;
      tick_n  = 1'b0;
      case (state)
         IDLE: begin
            div_n = '0;
            if (ev[B_START]) begin
               state_n = RUN;
               steps_n = bus.run_len;
               rl_n    = bus.run_len;
            end else if (ev[B_STEP]) begin
               state_n = STEP;
               tick_n  = 1'b1;
            end
         end
         RUN: begin
            // A stop on the terminal count freezes the divider and drops the tick.
            if (ev[B_STOP] || run_done) begin
               state_n = PAUSE;
            end else begin
               div_n = div_last ? '0 : div + 1'b1;
               if (div_last) begin
                  tick_n = 1'b1;
                  if ((rl_lat != 4'd0) && (steps != 4'd0)) steps_n = steps - 1'b1;
               end
            end
         end
         PAUSE: begin
            if (ev[B_STOP]) begin
               state_n = IDLE;
               steps_n = 4'd0;
               div_n   = '0;
            end else if (ev[B_START]) begin
               state_n = RUN;
               if (steps == 4'd0) begin
                  steps_n = bus.run_len;
                  rl_n    = bus.run_len;
               end
            end else if (ev[B_STEP]) begin
               state_n = STEP;
               tick_n  = 1'b1;
            end
         end
         STEP: begin
            state_n = PAUSE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         div    <= '0;
         steps  <= 4'd0;
         rl_lat <= 4'd0;
         tick_q <= 1'b0;
         up_q   <= 1'b1;
         ini_q  <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         state  <= state_n;
         div    <= div_n;
         steps  <= steps_n;
         rl_lat <= rl_n;
         tick_q <= tick_n;
         ini_q  <= (state_n == IDLE);
         busy_q <= (state_n == RUN);
         if (ev[B_DIR]) up_q <= ~up_q;
      end
   end

   assign bus.tick_en    = tick_q;
   assign bus.up         = up_q;
   assign bus.ini        = ini_q;
   assign bus.busy       = busy_q;
   assign bus.mode       = state;
   assign bus.steps_left = steps;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed vectors and corner-case sequences for seq_ctrl (DIV=4, DEB=3).
module tb_seq_ctrl;

   localparam int unsigned DIV = 4;
   localparam int unsigned DEB = 3;

   typedef struct {
      logic        st;
      logic        sp;
      logic        sq;
      logic        dr;
      logic [3:0]  rl;
      int          n;
      logic [11:0] exp;
   } vec_t;

   logic clock = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   vec_t vt [28];

   seq_ctrl_if bus ();

   seq_ctrl #(.DIV(DIV), .DIV_W(3), .DEB(DEB), .DEB_W(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Packed expectation: {mode, tick_en, ini, busy, up, steps_left}.
   function automatic logic [11:0] ex(input logic [1:0] m, input logic t, input logic i,
                                      input logic b, input logic u, input logic [3:0] s);
      return {m, t, i, b, u, s};
   endfunction

   function automatic vec_t mk(input logic st, input logic sp, input logic sq, input logic dr,
                               input int n, input logic [11:0] e);
      vec_t v;
      v.st = st; v.sp = sp; v.sq = sq; v.dr = dr; v.rl = 4'd3; v.n = n; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [11:0] e);
      logic [11:0] got;
      got = {bus.mode, bus.tick_en, bus.ini, bus.busy, bus.up, bus.steps_left};
      tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL %s: got mode=%0d tick=%0b ini=%0b busy=%0b up=%0b steps=%0d, expected mode=%0d tick=%0b ini=%0b busy=%0b up=%0b steps=%0d",
                  name, got[11:10], got[9], got[8], got[7], got[6], got[5:0],
                  e[11:10], e[9], e[8], e[7], e[6], e[5:0]);
      end
   endtask

   task automatic drive(input logic st, input logic sp, input logic sq, input logic dr);
      bus.btn_start = st;
      bus.btn_stop  = sp;
      bus.btn_step  = sq;
      bus.btn_dir   = dr;
   endtask

   // Advance n rising edges, land on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      // Bounded run of 3, stop to IDLE, two single steps, dir toggle, reload from PAUSE.
      vt[0]  = mk(0,0,0,0, 1, ex(2'd0,0,1,0,1,4'd0));
      vt[1]  = mk(1,0,0,0, 3, ex(2'd0,0,1,0,1,4'd0));
      vt[2]  = mk(1,0,0,0, 1, ex(2'd1,0,0,1,1,4'd3));
      vt[3]  = mk(0,0,0,0, 3, ex(2'd1,0,0,1,1,4'd3));
      vt[4]  = mk(0,0,0,0, 1, ex(2'd1,1,0,1,1,4'd2));
      vt[5]  = mk(0,0,0,0, 3, ex(2'd1,0,0,1,1,4'd2));
      vt[6]  = mk(0,0,0,0, 1, ex(2'd1,1,0,1,1,4'd1));
      vt[7]  = mk(0,0,0,0, 4, ex(2'd1,1,0,1,1,4'd0));
      vt[8]  = mk(0,0,0,0, 1, ex(2'd2,0,0,0,1,4'd0));
      vt[9]  = mk(0,0,0,0, 4, ex(2'd2,0,0,0,1,4'd0));
      vt[10] = mk(0,1,0,0, 3, ex(2'd2,0,0,0,1,4'd0));
      vt[11] = mk(0,1,0,0, 1, ex(2'd0,0,1,0,1,4'd0));
      vt[12] = mk(0,0,0,0, 3, ex(2'd0,0,1,0,1,4'd0));
      vt[13] = mk(0,0,1,0, 3, ex(2'd0,0,1,0,1,4'd0));
      vt[14] = mk(0,0,1,0, 1, ex(2'd3,1,0,0,1,4'd0));
      vt[15] = mk(0,0,0,0, 1, ex(2'd2,0,0,0,1,4'd0));
      vt[16] = mk(0,0,0,0, 2, ex(2'd2,0,0,0,1,4'd0));
      vt[17] = mk(0,0,1,0, 3, ex(2'd2,0,0,0,1,4'd0));
      vt[18] = mk(0,0,1,0, 1, ex(2'd3,1,0,0,1,4'd0));
      vt[19] = mk(0,0,0,0, 1, ex(2'd2,0,0,0,1,4'd0));
      vt[20] = mk(0,0,0,0, 2, ex(2'd2,0,0,0,1,4'd0));
      vt[21] = mk(0,0,0,1, 3, ex(2'd2,0,0,0,1,4'd0));
      vt[22] = mk(0,0,0,1, 1, ex(2'd2,0,0,0,0,4'd0));
      vt[23] = mk(0,0,0,0, 3, ex(2'd2,0,0,0,0,4'd0));
      vt[24] = mk(1,0,0,0, 3, ex(2'd2,0,0,0,0,4'd0));
      vt[25] = mk(1,0,0,0, 1, ex(2'd1,0,0,1,0,4'd3));
      vt[26] = mk(0,0,0,0, 3, ex(2'd1,0,0,1,0,4'd3));
      vt[27] = mk(0,0,0,0, 1, ex(2'd1,1,0,1,0,4'd2));

      reset = 1'b1;
      drive(0,0,0,0);
      bus.run_len = 4'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      chk("reset_state", ex(2'd0,0,1,0,1,4'd0));

      // Bouncing start, then a clean hold: one event, 4 edges after the final rise.
      drive(1,0,0,0); step(1);
      drive(0,0,0,0); step(1);
      drive(1,0,0,0); step(1);
      drive(0,0,0,0); step(1);
      chk("bounce_idle", ex(2'd0,0,1,0,1,4'd0));
      drive(1,0,0,0); step(3);
      chk("start_wait", ex(2'd0,0,1,0,1,4'd0));
      step(1);
      chk("start_ev", ex(2'd1,0,0,1,1,4'd0));

      // Free run with a dir press: tick every 4 cycles, up flips once, timing untouched.
      drive(1,0,0,1);
      for (int k = 1; k <= 12; k++) begin
         step(1);
         chk($sformatf("free_run_%0d", k),
             ex(2'd1, (k % 4) == 0, 1'b0, 1'b1, (k >= 4) ? 1'b0 : 1'b1, 4'd0));
      end

      // Asynchronous reset between edges while running.
      #2 reset = 1'b1;
      #1 chk("async_rst", ex(2'd0,0,1,0,1,4'd0));
      drive(0,0,0,0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Start and stop debounced together while running: stop wins.
      drive(1,0,0,0); step(4);
      chk("t6_run", ex(2'd1,0,0,1,1,4'd0));
      drive(0,0,0,0); step(3);
      drive(1,1,0,0); step(4);
      chk("t6_stop_wins", ex(2'd2,0,0,0,1,4'd0));
      drive(0,0,0,0); step(3);
      drive(0,1,0,0); step(4);
      chk("t6_idle", ex(2'd0,0,1,0,1,4'd0));
      drive(0,0,0,0); step(3);

      // Stop at divider 2, resume keeps the divider; then stop on the terminal count.
      drive(1,0,0,0); step(3);
      drive(1,1,0,0); step(1);
      chk("t4_run", ex(2'd1,0,0,1,1,4'd0));
      step(3);
      chk("t4_stop", ex(2'd2,0,0,0,1,4'd0));
      drive(0,0,0,0); step(3);
      drive(1,0,0,0); step(4);
      chk("t4_resume", ex(2'd1,0,0,1,1,4'd0));
      step(1);
      chk("t4_r1", ex(2'd1,0,0,1,1,4'd0));
      step(1);
      chk("t4_tick", ex(2'd1,1,0,1,1,4'd0));
      drive(1,1,0,0); step(3);
      chk("t4_pre", ex(2'd1,0,0,1,1,4'd0));
      step(1);
      chk("t4_coinc", ex(2'd2,0,0,0,1,4'd0));
      drive(0,0,0,0); step(3);
      drive(0,1,0,0); step(4);
      chk("t4_idle", ex(2'd0,0,1,0,1,4'd0));
      drive(0,0,0,0); step(4);

      for (int i = 0; i < 28; i++) begin
         drive(vt[i].st, vt[i].sp, vt[i].sq, vt[i].dr);
         bus.run_len = vt[i].rl;
         step(vt[i].n);
         chk($sformatf("vec%0d", i), vt[i].exp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
